// File: rtl/debug_trace_buffer.sv
// Trace capture buffer: samples CHANNELS parallel buses into a circular buffer,
// stops a programmable number of samples after a channel-0 trigger, and replays the window oldest-first.
module debug_trace_buffer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH)  // derived; leave at default
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      sample_en,
  input  logic [WIDTH*CHANNELS-1:0] sample_in,
  input  logic [WIDTH-1:0]          trig_value,
  input  logic [WIDTH-1:0]          trig_mask,
  input  logic                      force_trig,
  input  logic [AW:0]               post_count,
  input  logic                      rd_en,
  output logic [WIDTH*CHANNELS-1:0] rd_data,
  output logic                      rd_valid,
  output logic                      rd_last,
  output logic [1:0]                state,
  output logic [AW:0]               fill_count,
  output logic                      triggered
);

  localparam int          DW      = WIDTH * CHANNELS;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [AW:0]     post_q, post_d;
  logic [AW:0]     remain_q, remain_d;
  logic [AW:0]     rd_cnt_q, rd_cnt_d;
  logic            trig_q, trig_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;
  logic            wr_en;
  logic            match;
  logic            done_entry;

  logic [DW-1:0]   mem [DEPTH];

  assign match = sample_en &
                 (force_trig | (((sample_in[WIDTH-1:0] ^ trig_value) & trig_mask) == '0));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    post_d     = post_q;
    remain_d   = remain_q;
    rd_cnt_d   = rd_cnt_q;
    trig_d     = trig_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    wr_en      = 1'b0;
    done_entry = 1'b0;

    if (arm) begin
      // arm overrides everything, including a same-cycle sample or read
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      rd_cnt_d = '0;
      trig_d   = 1'b0;
      remain_d = '0;
      post_d   = (post_count > DEPTH_C) ? DEPTH_C : post_count;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (sample_en) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            fill_d   = (fill_q == DEPTH_C) ? fill_q : fill_q + (AW+1)'(1);
            if (match) begin
              trig_d = 1'b1;
              if (post_q == '0) begin
                done_entry = 1'b1;
              end else begin
                state_d  = S_POST;
                remain_d = post_q;
              end
            end
          end
        end
        S_POST: begin
          if (sample_en) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            fill_d   = (fill_q == DEPTH_C) ? fill_q : fill_q + (AW+1)'(1);
            remain_d = remain_q - (AW+1)'(1);
            if (remain_q == (AW+1)'(1)) done_entry = 1'b1;
          end
        end
        S_DONE: begin
          if (rd_en && (rd_cnt_q != fill_q)) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_last_d  = ((rd_cnt_q + (AW+1)'(1)) == fill_q);
            rd_ptr_d   = rd_ptr_q + AW'(1);
            rd_cnt_d   = rd_cnt_q + (AW+1)'(1);
          end
        end
        default: ;
      endcase
    end

    // Oldest entry sits fill_count behind the write pointer; a full buffer wraps to wr_ptr itself.
    if (done_entry) begin
      state_d  = S_DONE;
      rd_ptr_d = wr_ptr_d - fill_d[AW-1:0];
      rd_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      post_q     <= '0;
      remain_q   <= '0;
      rd_cnt_q   <= '0;
      trig_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      post_q     <= post_d;
      remain_q   <= remain_d;
      rd_cnt_q   <= rd_cnt_d;
      trig_q     <= trig_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_in;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;
  assign state      = state_q;
  assign fill_count = fill_q;
  assign triggered  = trig_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer: a cycle table for the basic capture/readout,
// then hand-written sequences for wrap, clamp, mask, zero post-count and reset/arm corners.
module tb_debug_trace_buffer;

  localparam int WIDTH = 16;
  localparam int CHANNELS = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int DW = WIDTH * CHANNELS;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm;
  logic          sample_en;
  logic [DW-1:0] sample_in;
  logic [15:0]   trig_value;
  logic [15:0]   trig_mask;
  logic          force_trig;
  logic [AW:0]   post_count;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic [1:0]    state;
  logic [AW:0]   fill_count;
  logic          triggered;

  int n_tests = 0;
  int n_fail  = 0;

  debug_trace_buffer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .sample_en  (sample_en),
    .sample_in  (sample_in),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .force_trig (force_trig),
    .post_count (post_count),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .state      (state),
    .fill_count (fill_count),
    .triggered  (triggered)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        a, se, ft, re;
    logic [15:0] c0;
    logic [1:0]  st;
    logic [4:0]  fc;
    logic        tr, rv, rl;
    logic [15:0] dc0;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [DW-1:0] pack(input logic [15:0] c0);
    logic [15:0] c1, c2, c3;
    c1 = c0 + 16'h1000;
    c2 = c0 + 16'h2000;
    c3 = c0 + 16'h3000;
    return {c3, c2, c1, c0};
  endfunction

  function automatic vec_t mkv(input logic a, se, ft, re, input logic [15:0] c0,
                               input logic [1:0] st, input logic [4:0] fc,
                               input logic tr, rv, rl, input logic [15:0] dc0);
    vec_t v;
    v.a = a; v.se = se; v.ft = ft; v.re = re; v.c0 = c0;
    v.st = st; v.fc = fc; v.tr = tr; v.rv = rv; v.rl = rl; v.dc0 = dc0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string pfx, input logic [1:0] st, input logic [4:0] fc,
                            input logic tr, input logic rv, input logic rl,
                            input logic [15:0] dc0, input logic chk_data);
    check({pfx, ".state"}, 64'(state), 64'(st));
    check({pfx, ".fill"}, 64'(fill_count), 64'(fc));
    check({pfx, ".triggered"}, 64'(triggered), 64'(tr));
    check({pfx, ".rd_valid"}, 64'(rd_valid), 64'(rv));
    check({pfx, ".rd_last"}, 64'(rd_last), 64'(rl));
    if (chk_data) check({pfx, ".rd_data"}, rd_data, pack(dc0));
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic step(input logic a, input logic se, input logic ft, input logic re,
                      input logic [15:0] c0);
    @(negedge clk);
    arm = a; sample_en = se; force_trig = ft; rd_en = re; sample_in = pack(c0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; sample_en = 1'b0; sample_in = '0; force_trig = 1'b0;
    rd_en = 1'b0; trig_value = 16'h0003; trig_mask = 16'hFFFF; post_count = 5'd2;
    #100;
    reset = 1'b0;
    @(negedge clk);
    expect_out("reset", 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("reset.rd_data", rd_data, 64'h0);

    // Basic capture: trigger on ch0=3, two post samples, readout of five entries.
    tbl[0]  = mkv(0, 1, 0, 1, 16'd3, 2'd0, 5'd0, 0, 0, 0, 16'd0);  // IDLE ignores all
    tbl[1]  = mkv(1, 1, 0, 0, 16'd3, 2'd1, 5'd0, 0, 0, 0, 16'd0);  // sample with arm dropped
    tbl[2]  = mkv(0, 1, 0, 0, 16'd1, 2'd1, 5'd1, 0, 0, 0, 16'd0);
    tbl[3]  = mkv(0, 1, 0, 0, 16'd2, 2'd1, 5'd2, 0, 0, 0, 16'd0);
    tbl[4]  = mkv(0, 1, 0, 0, 16'd3, 2'd2, 5'd3, 1, 0, 0, 16'd0);
    tbl[5]  = mkv(0, 1, 0, 0, 16'd4, 2'd2, 5'd4, 1, 0, 0, 16'd0);
    tbl[6]  = mkv(0, 1, 0, 0, 16'd5, 2'd3, 5'd5, 1, 0, 0, 16'd0);
    tbl[7]  = mkv(0, 1, 0, 0, 16'd9, 2'd3, 5'd5, 1, 0, 0, 16'd0);  // frozen
    tbl[8]  = mkv(0, 0, 0, 1, 16'd0, 2'd3, 5'd5, 1, 1, 0, 16'd1);
    tbl[9]  = mkv(0, 0, 0, 1, 16'd0, 2'd3, 5'd5, 1, 1, 0, 16'd2);
    tbl[10] = mkv(0, 0, 0, 0, 16'd0, 2'd3, 5'd5, 1, 0, 0, 16'd0);
    tbl[11] = mkv(0, 0, 0, 1, 16'd0, 2'd3, 5'd5, 1, 1, 0, 16'd3);
    tbl[12] = mkv(0, 0, 0, 1, 16'd0, 2'd3, 5'd5, 1, 1, 0, 16'd4);
    tbl[13] = mkv(0, 0, 0, 1, 16'd0, 2'd3, 5'd5, 1, 1, 1, 16'd5);
    tbl[14] = mkv(0, 0, 0, 1, 16'd0, 2'd3, 5'd5, 1, 0, 0, 16'd0);  // exhausted

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].a, tbl[i].se, tbl[i].ft, tbl[i].re, tbl[i].c0);
      expect_out($sformatf("basic[%0d]", i), tbl[i].st, tbl[i].fc, tbl[i].tr,
                 tbl[i].rv, tbl[i].rl, tbl[i].dc0, tbl[i].rv);
    end

    // Wrap: 30 samples, trigger on 20, four post samples; last 16 stored are 9..24.
    trig_value = 16'd20; trig_mask = 16'hFFFF; post_count = 5'd4;
    step(1, 0, 0, 0, 16'd0);
    for (int i = 0; i < 30; i++) begin
      step(0, 1, 0, 0, 16'(i));
      if (i == 19) check("wrap.armed_before_trig", 64'(state), 64'd1);
      if (i == 20) check("wrap.post_on_trig", 64'(state), 64'd2);
      if (i == 23) check("wrap.post_before_end", 64'(state), 64'd2);
      if (i == 24) check("wrap.done_after_24", 64'(state), 64'd3);
    end
    expect_out("wrap.end", 2'd3, 5'd16, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 16'd0);
      expect_out($sformatf("wrap.rd[%0d]", i), 2'd3, 5'd16, 1'b1, 1'b1,
                 (i == 15), 16'(9 + i), 1'b1);
    end
    step(0, 0, 0, 1, 16'd0);
    check("wrap.rd_after_last", 64'(rd_valid), 64'd0);

    // Clamp: post_count 31 acts as 16 post samples after a forced trigger.
    trig_value = 16'h0000; post_count = 5'd31;
    step(1, 0, 0, 0, 16'd0);
    step(0, 1, 1, 0, 16'd100);
    expect_out("clamp.trig", 2'd2, 5'd1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 0, 16'(100 + i));
      if (i == 15) check("clamp.still_post", 64'(state), 64'd2);
    end
    expect_out("clamp.done", 2'd3, 5'd16, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    step(0, 0, 0, 1, 16'd0);
    expect_out("clamp.rd0", 2'd3, 5'd16, 1'b1, 1'b1, 1'b0, 16'd101, 1'b1);

    // Mask: only bits 7:4 compared.
    trig_value = 16'h00F0; trig_mask = 16'h00F0; post_count = 5'd1;
    step(1, 0, 0, 0, 16'd0);
    step(0, 1, 0, 0, 16'h1204);
    expect_out("mask.nomatch", 2'd1, 5'd1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    step(0, 1, 0, 0, 16'h12F4);
    expect_out("mask.match", 2'd2, 5'd2, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);

    // Zero post count with forced trigger on the very first sample.
    trig_value = 16'h0000; trig_mask = 16'hFFFF; post_count = 5'd0;
    step(1, 0, 0, 0, 16'd0);
    step(0, 1, 1, 0, 16'h55AA);
    expect_out("post0.done", 2'd3, 5'd1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    step(0, 0, 0, 1, 16'd0);
    expect_out("post0.rd", 2'd3, 5'd1, 1'b1, 1'b1, 1'b1, 16'h55AA, 1'b1);
    step(0, 0, 0, 1, 16'd0);
    check("post0.rd_exhausted", 64'(rd_valid), 64'd0);

    // Asynchronous reset in the middle of POST.
    trig_value = 16'd7; post_count = 5'd3;
    step(1, 0, 0, 0, 16'd0);
    step(0, 1, 0, 0, 16'd7);
    step(0, 1, 0, 0, 16'd8);
    expect_out("rst.pre", 2'd2, 5'd2, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    sample_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    expect_out("rst.async", 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    check("rst.rd_data", rd_data, 64'h0);
    #1 reset = 1'b0;

    // arm and rd_en together in DONE: arm wins.
    post_count = 5'd0;
    step(1, 0, 0, 0, 16'd0);
    step(0, 1, 1, 0, 16'h0042);
    check("armrd.pre_done", 64'(state), 64'd3);
    step(1, 0, 0, 1, 16'd0);
    expect_out("armrd", 2'd1, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    step(0, 0, 0, 0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
- Synthesizable trace-capture block for the 16-bit MIPS core; replaces hand-probing of internal buses (instruction, ALU result, register taps) from the bench.
- Samples CHANNELS parallel buses of WIDTH bits each into a circular buffer of DEPTH entries.
- Stops capture a programmable number of samples after a masked trigger match on channel 0.
- Replays the captured window oldest-first through a read handshake.

Parameters:
- WIDTH, 16, bits per channel.
- CHANNELS, 4, number of sampled buses; channel 0 occupies sample_in[WIDTH-1:0].
- DEPTH, 16, buffer entries; must be a power of 2, minimum 2.
- AW, log2(DEPTH), derived pointer width; not overridden by the user.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  one-cycle pulse; clears the buffer and starts pre-trigger capture.
- sample_en  in  1  qualifies sample_in this cycle.
- sample_in  in  WIDTH*CHANNELS  packed channel data.
- trig_value  in  WIDTH  compare value for channel 0.
- trig_mask  in  WIDTH  1 = bit participates in the compare.
- force_trig  in  1  treated as a trigger match when sample_en=1.
- post_count  in  AW+1  samples captured after the trigger sample; values above DEPTH clamp to DEPTH; latched on arm.
- rd_en  in  1  request next stored entry (DONE state only).
- rd_data  out  WIDTH*CHANNELS  replayed entry.
- rd_valid  out  1  rd_data valid this cycle.
- rd_last  out  1  with rd_valid, marks the final stored entry.
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- fill_count  out  AW+1  entries held; saturates at DEPTH.
- triggered  out  1  sticky; set on the trigger sample.

Behaviour:
- Reset (async): state=IDLE, all pointers=0, fill_count=0, triggered=0, rd_valid=0, rd_last=0, rd_data=0. Memory contents are not reset.
- Reset mid-capture or mid-readout aborts immediately, returning to the reset values above.
- arm (any state, highest priority):
  - Next cycle: state=ARMED, wr_ptr=0, fill_count=0, triggered=0, rd_valid=0.
  - post_count is latched (clamped).
  - A sample_en in the same cycle as arm is dropped.
- IDLE: sample_en and rd_en are ignored.
- ARMED:
  - Each sample_en writes mem[wr_ptr]; wr_ptr increments mod DEPTH; fill_count increments, saturating at DEPTH (oldest entry overwritten).
  - Match = sample_en & (force_trig | (((ch0 ^ trig_value) & trig_mask) == 0)).
  - On a match, the sample is written and triggered=1.
  - Latched post_count=0: next state=DONE. Otherwise: next state=POST, remaining=post_count.
  - trig_mask=0 means the first sample always triggers.
- POST: each sample_en writes as in ARMED and decrements remaining; the write that takes remaining to 0 moves the state to DONE the next cycle. Further triggers are ignored.
- DONE:
  - Capture is frozen.
  - The read pointer initialises on DONE entry to oldest = (wr_ptr - fill_count) mod DEPTH.
  - Each rd_en while entries remain gives rd_data = the next entry with rd_valid=1 one cycle later; the pointer advances.
  - rd_last=1 with the fill_count-th entry.
  - rd_en after exhaustion: rd_valid stays 0.
  - rd_en while not in DONE: ignored.
  - Back-to-back rd_en yields one entry per cycle.
- Wrap-around: pointer arithmetic is mod DEPTH. After more than DEPTH total samples, readout returns exactly the last DEPTH samples in order.
- Simultaneous arm+rd_en: arm wins; no read is returned.

Test Plan:
- Reset asserted for 100 ns, then released -> state=0, fill_count=0, rd_valid=0, triggered=0; sample_en ignored until arm.
- Defaults; arm with post_count=2, trig_value=0x0003, mask=0xFFFF; samples with ch0=1..5 -> triggered after ch0=3; state=3 after ch0=5; fill_count=5; 5 reads return ch0=1,2,3,4,5 with rd_last on 5; a 6th rd_en gives rd_valid=0.
- Wrap: post_count=4, trig_value=20; 30 samples ch0=0..29 -> DONE after ch0=24; fill_count=16; readout ch0=9..24; samples 25..29 not stored.
- Mask: trig_value=0x00F0, mask=0x00F0; ch0=0x1204 -> no trigger; ch0=0x12F4 -> triggered=1 on that sample.
- post_count=0 with force_trig on the first sample_en -> state=DONE the next cycle; fill_count=1; one read returns that sample with rd_last=1.
- Async reset during POST -> outputs immediately at reset values. Then arm asserted in the same cycle as rd_en while in DONE -> state=1, no rd_valid, fill_count=0.
